// File: rtl/ahb_ctrl_pkg.sv
// Shared definitions for the AHB-Lite master controller and its datapath:
// bus encodings, controller state encoding and the burst-length mapping.
package ahb_ctrl_pkg;

  // Largest undefined-length INCR burst; the beat counter is sized to hold it.
  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 5;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HBURST encodings, also decoded by the datapath for address wrapping
  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  // Widest transfer the datapath supports (word)
  localparam logic [2:0] HSIZE_MAX = 3'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADDR  = 3'd2,
    DATA  = 3'd3,
    ERR   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Beat total for a burst. A zero INCR length runs as a single beat; an
  // oversized INCR length is clamped so the counter can never overflow.
  function automatic logic [CNT_W-1:0] burst_beats(input logic [2:0]       burst,
                                                   input logic [CNT_W-1:0] len);
    logic [CNT_W-1:0] beats;
    case (burst)
      HBURST_SINGLE: beats = CNT_W'(1);
      HBURST_INCR: begin
        if (len == '0)                 beats = CNT_W'(1);
        else if (len > CNT_W'(MAX_LEN)) beats = CNT_W'(MAX_LEN);
        else                           beats = len;
      end
      HBURST_WRAP4,  HBURST_INCR4:  beats = CNT_W'(4);
      HBURST_WRAP8,  HBURST_INCR8:  beats = CNT_W'(8);
      HBURST_WRAP16, HBURST_INCR16: beats = CNT_W'(16);
      default:                      beats = CNT_W'(1);
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb_burst_len.sv
// Combinational beat-total decoder used when a command is accepted.
module ahb_burst_len
  import ahb_ctrl_pkg::*;
(
  input  logic [2:0]       cmd_burst,
  input  logic [CNT_W-1:0] cmd_len,
  output logic [CNT_W-1:0] beats
);

  assign beats = burst_beats(cmd_burst, cmd_len);

endmodule

// File: rtl/ahb_master_ctrl.sv
// AHB-Lite master sequencing controller. Runs one burst command at a time
// as non-overlapped ADDR/DATA beat pairs and strobes the datapath.
module ahb_master_ctrl
  import ahb_ctrl_pkg::*;
(
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [2:0]       cmd_burst,
  input  logic [2:0]       cmd_size,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             HREADY,
  input  logic             HRESP,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       burst_out,
  output logic [2:0]       size_out,
  output logic             start_out,
  output logic             next_beat,
  output logic             store_read,
  output logic             done,
  output logic             error
);

  state_t           state_reg, state_next;
  logic             write_reg, write_next;
  logic [2:0]       burst_reg, burst_next;
  logic [2:0]       size_reg,  size_next;
  logic [CNT_W-1:0] total_reg, total_next;
  logic [CNT_W-1:0] cnt_reg,   cnt_next;
  logic             err_reg,   err_next;
  logic [CNT_W-1:0] cmd_beats;
  logic             more_beats;

  ahb_burst_len u_burst_len (
    .cmd_burst (cmd_burst),
    .cmd_len   (cmd_len),
    .beats     (cmd_beats)
  );

  // True while the current beat is not the last one of the burst; widened so
  // counter+1 cannot wrap when the total is 16.
  assign more_beats = ({1'b0, cnt_reg} + (CNT_W+1)'(1)) < {1'b0, total_reg};

  // State and command registers; reset is asynchronous so a mid-burst reset
  // drops everything immediately with no done pulse.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg <= IDLE;
      write_reg <= 1'b0;
      burst_reg <= 3'd0;
      size_reg  <= 3'd0;
      total_reg <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      write_reg <= write_next;
      burst_reg <= burst_next;
      size_reg  <= size_next;
      total_reg <= total_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic plus the beat-completion strobes, which must coincide
  // with the HREADY edge that ends the data phase.
  always_comb begin
    state_next = state_reg;
    write_next = write_reg;
    burst_next = burst_reg;
    size_next  = size_reg;
    total_next = total_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    next_beat  = 1'b0;
    store_read = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          write_next = cmd_write;
          burst_next = cmd_burst;
          size_next  = cmd_size;
          total_next = cmd_beats;
          cnt_next   = '0;
          if (cmd_size > HSIZE_MAX) begin
            err_next   = 1'b1;
            state_next = DONE;
          end else begin
            err_next   = 1'b0;
            state_next = START;
          end
        end
      end
      START: state_next = ADDR;
      ADDR: begin
        if (HREADY) state_next = DATA;
      end
      DATA: begin
        if (HREADY) begin
          store_read = ~write_reg;
          if (more_beats) begin
            next_beat  = 1'b1;
            cnt_next   = cnt_reg + CNT_W'(1);
            state_next = ADDR;
          end else begin
            state_next = DONE;
          end
        end else if (HRESP) begin
          state_next = ERR;
        end
      end
      ERR: begin
        if (HREADY) begin
          err_next   = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus and handshake outputs decoded from registered state only, keeping
  // HREADY/HRESP out of the HTRANS path.
  always_comb begin
    cmd_ready = (state_reg == IDLE);
    start_out = (state_reg == START);
    done      = (state_reg == DONE);
    error     = (state_reg == DONE) & err_reg;
    HTRANS    = HTRANS_IDLE;
    case (state_reg)
      ADDR:    HTRANS = (cnt_reg == '0) ? HTRANS_NONSEQ : HTRANS_SEQ;
      DATA:    HTRANS = more_beats ? HTRANS_BUSY : HTRANS_IDLE;
      default: HTRANS = HTRANS_IDLE;
    endcase
  end

  assign HWRITE    = write_reg;
  assign burst_out = burst_reg;
  assign size_out  = size_reg;

endmodule

// File: tb/tb_ahb_master_ctrl.sv
// Directed bench for ahb_master_ctrl: a per-cycle bus trace and a
// per-command scoreboard, plus a small datapath address model.
module tb_ahb_master_ctrl;
  import ahb_ctrl_pkg::*;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [2:0] cmd_burst = 3'd0;
  logic [2:0] cmd_size = 3'd0;
  logic [4:0] cmd_len = 5'd0;
  logic       HREADY = 1'b1;
  logic       HRESP = 1'b0;
  logic [1:0] HTRANS;
  logic       HWRITE;
  logic [2:0] burst_out;
  logic [2:0] size_out;
  logic       start_out;
  logic       next_beat;
  logic       store_read;
  logic       done;
  logic       error;

  ahb_master_ctrl dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_burst  (cmd_burst),
    .cmd_size   (cmd_size),
    .cmd_len    (cmd_len),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .burst_out  (burst_out),
    .size_out   (size_out),
    .start_out  (start_out),
    .next_beat  (next_beat),
    .store_read (store_read),
    .done       (done),
    .error      (error)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One expected bus cycle after command acceptance
  typedef struct {
    logic       hready;
    logic       hresp;
    logic [1:0] htrans;
    logic       done;
  } step_t;

  // Expected per-command totals, checked when done pulses
  typedef struct {
    string tag;
    int    done_cyc;
    logic  err;
    int    n_start;
    int    n_read;
    int    n_next;
    logic  wr;
    logic [2:0] burst;
    logic [2:0] size;
  } exp_t;

  step_t trace_q[$];
  exp_t  exp_q[$];

  // Datapath address model driven by the controller strobes
  logic [31:0] start_addr = 32'd0;
  logic [31:0] dp_addr = 32'd0;
  logic [31:0] cap_q[$];

  function automatic logic [31:0] dp_next(input logic [31:0] a, input logic [2:0] b,
                                          input logic [2:0] s);
    logic [31:0] inc;
    logic [31:0] span;
    inc = 32'd1 << s;
    case (b)
      HBURST_WRAP4:  span = inc << 2;
      HBURST_WRAP8:  span = inc << 3;
      HBURST_WRAP16: span = inc << 4;
      default:       span = 32'd0;
    endcase
    if (span == 32'd0) return a + inc;
    return (a & ~(span - 32'd1)) | ((a + inc) & (span - 32'd1));
  endfunction

  // Capture at the old address, then advance, on the same edge
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) dp_addr <= 32'd0;
    else begin
      if (store_read) cap_q.push_back(dp_addr);
      if (start_out) dp_addr <= start_addr;
      else if (next_beat) dp_addr <= dp_next(dp_addr, burst_out, size_out);
    end
  end

  // Scoreboard monitor: counts strobes per command, pops on done
  bit mon_active = 1'b0;
  int mon_cyc, mon_start, mon_read, mon_next;
  always @(negedge HCLK) begin
    if (!HRESETn) mon_active = 1'b0;
    else begin
      if (mon_active) begin
        mon_cyc++;
        mon_start += int'(start_out);
        mon_read  += int'(store_read);
        mon_next  += int'(next_beat);
        if (done) begin
          if (exp_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
          else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, "_done_cycle"}, 32'(mon_cyc), 32'(e.done_cyc));
            check({e.tag, "_error"}, 32'(error), 32'(e.err));
            check({e.tag, "_start_pulses"}, 32'(mon_start), 32'(e.n_start));
            check({e.tag, "_store_read_pulses"}, 32'(mon_read), 32'(e.n_read));
            check({e.tag, "_next_beat_pulses"}, 32'(mon_next), 32'(e.n_next));
            check({e.tag, "_hwrite"}, 32'(HWRITE), 32'(e.wr));
            check({e.tag, "_burst_out"}, 32'(burst_out), 32'(e.burst));
            check({e.tag, "_size_out"}, 32'(size_out), 32'(e.size));
            $display("txn %s: done at cycle %0d error=%0b reads=%0d nexts=%0d",
                     e.tag, mon_cyc, error, mon_read, mon_next);
          end
          mon_active = 1'b0;
        end
      end else if (done) begin
        check("done_while_idle", 32'(done), 32'd0);
      end
      if (cmd_valid && cmd_ready) begin
        mon_active = 1'b1;
        mon_cyc    = 0;
        mon_start  = 0;
        mon_read   = 0;
        mon_next   = 0;
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_htrans"}, 32'(HTRANS), 32'(HTRANS_IDLE));
    check({tag, "_hwrite"}, 32'(HWRITE), 32'd0);
    check({tag, "_burst_out"}, 32'(burst_out), 32'd0);
    check({tag, "_size_out"}, 32'(size_out), 32'd0);
    check({tag, "_start_out"}, 32'(start_out), 32'd0);
    check({tag, "_next_beat"}, 32'(next_beat), 32'd0);
    check({tag, "_store_read"}, 32'(store_read), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  // Issue one command from a posedge+1 point and follow it cycle by cycle.
  // wait_beat/err_beat are 0-based beat indices (-1 = none); abort_cyc>0
  // asserts HRESETn in that cycle after acceptance.
  task automatic run_cmd(input string tag, input logic wr, input logic [2:0] burst,
                         input logic [2:0] size, input logic [4:0] len,
                         input logic [31:0] addr, input int wait_beat, input int nwait,
                         input int err_beat, input int abort_cyc);
    int    n;
    int    completed;
    int    cyc;
    int    nw;
    bit    hit_err;
    logic [1:0] dt;
    exp_t  e;
    step_t s;

    case (burst)
      HBURST_SINGLE:               n = 1;
      HBURST_INCR:                 n = (len == 5'd0) ? 1 : int'(len);
      HBURST_WRAP4, HBURST_INCR4:  n = 4;
      HBURST_WRAP8, HBURST_INCR8:  n = 8;
      default:                     n = 16;
    endcase

    trace_q.delete();
    completed = 0;
    hit_err   = 1'b0;
    if (size > 3'd2) begin
      trace_q.push_back('{1'b1, 1'b0, HTRANS_IDLE, 1'b1});
      e.err = 1'b1; e.n_start = 0; e.n_read = 0; e.n_next = 0;
    end else begin
      trace_q.push_back('{1'b1, 1'b0, HTRANS_IDLE, 1'b0});
      for (int b = 0; b < n; b++) begin
        dt = (b < n - 1) ? HTRANS_BUSY : HTRANS_IDLE;
        trace_q.push_back('{1'b1, 1'b0, (b == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b0});
        if (b == err_beat) begin
          trace_q.push_back('{1'b0, 1'b1, dt, 1'b0});
          trace_q.push_back('{1'b1, 1'b1, HTRANS_IDLE, 1'b0});
          hit_err = 1'b1;
          break;
        end
        nw = (b == wait_beat) ? nwait : 0;
        for (int w = 0; w < nw; w++) trace_q.push_back('{1'b0, 1'b0, dt, 1'b0});
        trace_q.push_back('{1'b1, 1'b0, dt, 1'b0});
        completed++;
      end
      trace_q.push_back('{1'b1, 1'b0, HTRANS_IDLE, 1'b1});
      e.err     = hit_err;
      e.n_start = 1;
      e.n_read  = wr ? 0 : completed;
      e.n_next  = hit_err ? completed : completed - 1;
    end
    e.tag      = tag;
    e.done_cyc = trace_q.size();
    e.wr       = wr;
    e.burst    = burst;
    e.size     = size;

    cmd_valid  = 1'b1;
    cmd_write  = wr;
    cmd_burst  = burst;
    cmd_size   = size;
    cmd_len    = len;
    start_addr = addr;
    HREADY     = 1'b1;
    HRESP      = 1'b0;
    check({tag, "_ready_at_issue"}, 32'(cmd_ready), 32'd1);
    if (abort_cyc == 0) exp_q.push_back(e);
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;

    cyc = 0;
    while (trace_q.size() > 0) begin
      s = trace_q.pop_front();
      cyc++;
      HREADY = s.hready;
      HRESP  = s.hresp;
      if (cyc == abort_cyc) begin
        #2;
        HRESETn = 1'b0;
        #1;
        check_reset_values({tag, "_async_reset"});
        $display("txn %s: reset asserted in cycle %0d", tag, cyc);
        exp_q.delete();
        trace_q.delete();
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        HREADY  = 1'b1;
        HRESP   = 1'b0;
        return;
      end
      @(negedge HCLK);
      check($sformatf("%s_htrans_c%0d", tag, cyc), 32'(HTRANS), 32'(s.htrans));
      check($sformatf("%s_done_c%0d", tag, cyc), 32'(done), 32'(s.done));
      check($sformatf("%s_cmd_ready_c%0d", tag, cyc), 32'(cmd_ready), 32'd0);
      @(posedge HCLK); #1;
    end
    HREADY = 1'b1;
    HRESP  = 1'b0;
  endtask

  initial begin
    #1;
    check_reset_values("por");
    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    // SINGLE read at 0x10, word size, zero wait
    cap_q.delete();
    run_cmd("single_rd", 1'b0, HBURST_SINGLE, 3'd2, 5'd0, 32'h10, -1, 0, -1, 0);
    check("single_rd_cap_count", 32'(cap_q.size()), 32'd1);
    if (cap_q.size() == 1) check("single_rd_cap_addr", cap_q[0], 32'h10);

    // INCR4 write issued back to back (cycle 5 after the previous accept)
    run_cmd("incr4_wr", 1'b1, HBURST_INCR4, 3'd2, 5'd0, 32'h100, -1, 0, -1, 0);

    // WRAP4 read from 0x0C with 2 wait states on the first beat
    cap_q.delete();
    run_cmd("wrap4_rd", 1'b0, HBURST_WRAP4, 3'd2, 5'd0, 32'h0C, 0, 2, -1, 0);
    check("wrap4_rd_cap_count", 32'(cap_q.size()), 32'd4);
    if (cap_q.size() == 4) begin
      check("wrap4_rd_addr0", cap_q[0], 32'h0C);
      check("wrap4_rd_addr1", cap_q[1], 32'h00);
      check("wrap4_rd_addr2", cap_q[2], 32'h04);
      check("wrap4_rd_addr3", cap_q[3], 32'h08);
    end

    // INCR8 read, error response on the third beat
    run_cmd("incr8_err", 1'b0, HBURST_INCR8, 3'd1, 5'd0, 32'h200, -1, 0, 2, 0);

    // Illegal transfer size
    run_cmd("bad_size", 1'b1, HBURST_INCR4, 3'd3, 5'd0, 32'h0, -1, 0, -1, 0);

    // Reset during the second beat of an INCR16, then normal traffic
    run_cmd("incr16_rst", 1'b0, HBURST_INCR16, 3'd2, 5'd0, 32'h300, -1, 0, -1, 5);
    run_cmd("incr3_rd", 1'b0, HBURST_INCR, 3'd0, 5'd3, 32'h40, 1, 1, -1, 0);
    run_cmd("incr0_wr", 1'b1, HBURST_INCR, 3'd1, 5'd0, 32'h50, -1, 0, -1, 0);
    run_cmd("incr16_wr", 1'b1, HBURST_INCR, 3'd2, 5'd16, 32'h60, 15, 1, -1, 0);

    repeat (2) @(posedge HCLK);
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
